pc_unit: RTL and testbench

- Parametrised program counter for the fetch stage. Successor to the fixed 8-bit, always-+4 counter.
- Adds a synchronous reset vector, a valid/ready handshake to fetch, stall and halt, and prioritised redirects (trap, jump, branch).
- Adds misaligned-target detection and an issued-address counter.
- Sits between the control/branch-resolution logic and the instruction-memory address port.

---
 rtl/pc_unit.sv | 97 +++++++++
 tb/tb_pc_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: reset vector, valid/ready handshake to fetch,
// stall/halt control, prioritised redirects and misaligned-target trapping.
module pc_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                INC       = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(8'hF0),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_ready,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  input  logic              trap,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic              misalign,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // INC is a power of two, so its low bits form the alignment mask; INC=1 gives 0.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INC);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              misalign_next;
  logic              accept;
  logic              redirect;
  logic              jump_mis;
  logic              branch_mis;

  assign pc_valid   = (state == RUN);
  assign accept     = pc_valid && pc_ready;
  assign redirect   = trap || jump_valid || branch_valid;
  assign jump_mis   = (jump_target & ALIGN_MASK) != '0;
  assign branch_mis = (branch_target & ALIGN_MASK) != '0;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_next    = state;
    pc_next       = pc_out;
    misalign_next = 1'b0;

    // Redirects resolve identically in RUN and HALT; BOOT ignores them.
    if (state != BOOT) begin
      if (trap) begin
        pc_next = TRAP_VEC;
      end else if (jump_valid) begin
        pc_next       = jump_mis ? TRAP_VEC : jump_target;
        misalign_next = jump_mis;
      end else if (branch_valid) begin
        pc_next       = branch_mis ? TRAP_VEC : branch_target;
        misalign_next = branch_mis;
      end else if (accept && !stall) begin
        pc_next = pc_out + STEP;
      end
    end

    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (halt && !redirect) state_next = HALT;
      HALT:    if (resume || trap) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc_out    <= RESET_VEC;
      misalign  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state    <= state_next;
      pc_out   <= pc_next;
      misalign <= misalign_next;
      if (accept) fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic,
// checked against an arithmetic reference model on an 8-bit and a 12-bit instance.
module tb_pc_unit;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct {
    int st;
    int pc;
    int mis;
    int cnt;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst, pc_ready, stall, halt, resume, trap, jv, bv;
  logic [7:0]  jt8, bt8;
  logic [11:0] jt12, bt12;
  logic        sep12;

  logic [7:0]  pc8;
  logic        val8, mis8;
  logic [15:0] cnt8;
  logic [11:0] pc12;
  logic        val12, mis12;
  logic [15:0] cnt12;

  int   checks   = 0;
  int   failures = 0;
  mdl_t m8, m12;

  always #5 clk = ~clk;

  pc_unit u8 (
    .clk(clk), .rst(rst), .pc_ready(pc_ready), .stall(stall), .halt(halt),
    .resume(resume), .trap(trap), .jump_valid(jv), .jump_target(jt8),
    .branch_valid(bv), .branch_target(bt8), .pc_out(pc8), .pc_valid(val8),
    .misalign(mis8), .fetch_cnt(cnt8)
  );

  pc_unit #(.ADDR_W(12), .INC(2)) u12 (
    .clk(clk), .rst(rst), .pc_ready(pc_ready), .stall(stall), .halt(halt),
    .resume(resume), .trap(trap), .jump_valid(jv), .jump_target(jt12),
    .branch_valid(bv), .branch_target(bt12), .pc_out(pc12), .pc_valid(val12),
    .misalign(mis12), .fetch_cnt(cnt12)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one clock edge of the fetch PC, from the architectural rules.
  function automatic mdl_t mstep(mdl_t m, int aw, int inc, int tv, int jt, int bt);
    mdl_t n;
    int   modulus;
    n       = m;
    modulus = 1 << aw;
    n.mis   = 0;
    if (rst) begin
      n.st = M_BOOT; n.pc = 0; n.cnt = 0;
      return n;
    end
    if (m.st == M_RUN && pc_ready) n.cnt = (m.cnt + 1) % 65536;
    if (m.st == M_BOOT) begin
      n.st = M_RUN;
      return n;
    end
    if (trap) n.pc = tv;
    else if (jv) begin
      if (jt % inc != 0) begin n.pc = tv; n.mis = 1; end
      else n.pc = jt;
    end else if (bv) begin
      if (bt % inc != 0) begin n.pc = tv; n.mis = 1; end
      else n.pc = bt;
    end else if (m.st == M_RUN && pc_ready && !stall) n.pc = (m.pc + inc) % modulus;
    if (m.st == M_RUN && halt && !(trap || jv || bv)) n.st = M_HALT;
    else if (m.st == M_HALT && (resume || trap)) n.st = M_RUN;
    return n;
  endfunction

  task automatic idle();
    rst = 0; pc_ready = 0; stall = 0; halt = 0; resume = 0;
    trap = 0; jv = 0; bv = 0;
  endtask

  // One clock: advance the model on the applied inputs, then compare both DUTs.
  task automatic cyc();
    if (!sep12) begin
      jt12 = {4'h0, jt8};
      bt12 = {4'h0, bt8};
    end
    m8  = mstep(m8, 8, 4, 'hF0, int'(jt8), int'(bt8));
    m12 = mstep(m12, 12, 2, 'hF0, int'(jt12), int'(bt12));
    @(posedge clk);
    #1;
    check("pc8",    32'(pc8),   32'(m8.pc));
    check("val8",   32'(val8),  32'(m8.st == M_RUN));
    check("mis8",   32'(mis8),  32'(m8.mis));
    check("cnt8",   32'(cnt8),  32'(m8.cnt));
    check("pc12",   32'(pc12),  32'(m12.pc));
    check("val12",  32'(val12), 32'(m12.st == M_RUN));
    check("mis12",  32'(mis12), 32'(m12.mis));
    check("cnt12",  32'(cnt12), 32'(m12.cnt));
  endtask

  initial begin
    m8 = '{default: 0};
    m12 = '{default: 0};
    sep12 = 0; jt8 = 0; bt8 = 0; jt12 = 0; bt12 = 0;
    idle();

    // Reset, then five ready cycles: one BOOT cycle then 0,4,8,12.
    rst = 1; cyc();
    check("rst_pc", 32'(pc8), 32'h0);
    check("rst_valid", 32'(val8), 32'h0);
    check("rst_cnt", 32'(cnt8), 32'h0);
    idle(); pc_ready = 1;
    cyc(); check("boot_pc0", 32'(pc8), 32'h0); check("boot_valid", 32'(val8), 32'h1);
    cyc(); check("seq_pc4", 32'(pc8), 32'h4);
    cyc(); check("seq_pc8", 32'(pc8), 32'h8);
    cyc(); check("seq_pc12", 32'(pc8), 32'hC);
    cyc(); check("seq_cnt4", 32'(cnt8), 32'h4);

    // Back-pressure and stall at pc 8.
    idle(); jv = 1; jt8 = 8'h08; cyc();
    idle();
    for (int i = 0; i < 3; i++) cyc();
    check("ready_low_hold", 32'(pc8), 32'h8);
    stall = 1; pc_ready = 1; cyc(); cyc();
    check("stall_hold", 32'(pc8), 32'h8);
    check("stall_cnt", 32'(cnt8), 32'h6);
    stall = 0; cyc();
    check("stall_release", 32'(pc8), 32'hC);

    // Redirect priority.
    idle(); trap = 1; jv = 1; jt8 = 8'h40; bv = 1; bt8 = 8'h80; cyc();
    check("prio_trap", 32'(pc8), 32'hF0);
    trap = 0; cyc();
    check("prio_jump", 32'(pc8), 32'h40);

    // Misaligned branch target traps and pulses misalign once.
    idle(); bv = 1; bt8 = 8'h42; cyc();
    check("mis_pc", 32'(pc8), 32'hF0);
    check("mis_pulse", 32'(mis8), 32'h1);
    idle(); cyc();
    check("mis_clear", 32'(mis8), 32'h0);

    // Wrap-around from 8'hF8.
    jv = 1; jt8 = 8'hF8; cyc();
    idle(); pc_ready = 1;
    cyc(); check("wrap_fc", 32'(pc8), 32'hFC);
    cyc(); check("wrap_00", 32'(pc8), 32'h00);
    cyc(); check("wrap_04", 32'(pc8), 32'h04);

    // Halt, redirect while halted, resume.
    idle(); jv = 1; jt8 = 8'h20; cyc();
    idle(); halt = 1; cyc();
    check("halt_valid", 32'(val8), 32'h0);
    check("halt_pc", 32'(pc8), 32'h20);
    idle(); jv = 1; jt8 = 8'h30; cyc();
    check("halt_jump_pc", 32'(pc8), 32'h30);
    check("halt_jump_valid", 32'(val8), 32'h0);
    idle(); resume = 1; cyc();
    check("resume_valid", 32'(val8), 32'h1);
    check("resume_pc", 32'(pc8), 32'h30);

    // Reset mid-run beats a simultaneous trap.
    idle(); pc_ready = 1; cyc(); cyc();
    rst = 1; trap = 1; cyc();
    check("rst_mid_pc", 32'(pc8), 32'h0);
    check("rst_mid_cnt", 32'(cnt8), 32'h0);
    check("rst_mid_valid", 32'(val8), 32'h0);

    // 12-bit, INC=2 instance: wrap at 12'hFFE and odd branch target.
    idle(); pc_ready = 1; cyc();
    sep12 = 1; jv = 1; jt8 = 8'h40; jt12 = 12'hFFE; cyc();
    check("w12_ffe", 32'(pc12), 32'hFFE);
    jv = 0; cyc();
    check("w12_wrap", 32'(pc12), 32'h000);
    bv = 1; bt8 = 8'h44; bt12 = 12'h003; cyc();
    check("w12_mis_pc", 32'(pc12), 32'h0F0);
    check("w12_mis", 32'(mis12), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(99) < 1);
      pc_ready = ($urandom_range(99) < 70);
      stall    = ($urandom_range(99) < 20);
      halt     = ($urandom_range(99) < 6);
      resume   = ($urandom_range(99) < 30);
      trap     = ($urandom_range(99) < 3);
      jv       = ($urandom_range(99) < 6);
      bv       = ($urandom_range(99) < 8);
      jt8      = 8'($urandom);
      bt8      = 8'($urandom);
      jt12     = 12'($urandom);
      bt12     = 12'($urandom);
      if ($urandom_range(1) == 0) begin
        jt8 = jt8 & 8'hFC; bt8 = bt8 & 8'hFC;
        jt12 = jt12 & 12'hFFE; bt12 = bt12 & 12'hFFE;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
